fifo_prog_flags: RTL and testbench
==================================

# fifo_prog_flags

Synchronous single-clock FIFO with runtime-programmable almost-full and almost-empty thresholds, an occupancy count output, and sticky overflow/underflow error flags. It is the parametrised successor to the team's fixed-threshold FIFO. It sits between producer and consumer datapaths in the same clock domain, where the thresholds drive flow control and the error flags feed status registers.

## Interface
- DATA_WIDTH, 8: width of din/dout.
- ADDR_WIDTH, 4: log2 of depth. DEPTH is derived as 2**ADDR_WIDTH (local constant, not overridable).
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- dout  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- af_thresh  in  ADDR_WIDTH+1  almost-full threshold.
- ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold.
- almost_full  out  1  count >= af_thresh.
- almost_empty  out  1  count <= ae_thresh.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a write was attempted while full.
- underflow  out  1  sticky flag: a read was attempted while empty.
- clr_err  in  1  clears overflow and underflow.

## Operation
- Pointers wptr and rptr are ADDR_WIDTH+1 bits wide and wrap naturally modulo 2*DEPTH. Memory is addressed by the low ADDR_WIDTH bits.
- A write is accepted iff wr_en && !full. It stores din at mem[waddr], then wptr increments.
- A read is accepted iff rd_en && !empty. rptr increments.
- Full and empty are evaluated on pre-edge state:
  - When full, a simultaneous read and write gives read accepted, write rejected, overflow set.
  - When empty, a simultaneous read and write gives write accepted, read rejected, underflow set.
  - When neither full nor empty, both are accepted and count is unchanged.
- count is a register: +1 on write only, -1 on read only, unchanged otherwise.
- full, empty, almost_full and almost_empty are combinational from count and the thresholds. Threshold inputs may change at any time and take effect immediately.
  - af_thresh = 0 forces almost_full high.
  - ae_thresh >= DEPTH forces almost_empty high.
- overflow is set on wr_en && full; underflow is set on rd_en && empty. Each stays set until clr_err. If a set and clr_err occur in the same cycle, the set wins.
- Rejected operations never modify pointers, count or memory.
- Reset values:
  - wptr, rptr and count are 0.
  - dout is 0.
  - overflow and underflow are 0.
  - empty = 1, full = 0.
  - almost_empty = 1, almost_full = (af_thresh == 0).
  - Memory contents are not reset.
- Reset mid-operation discards all contents. Any in-flight write or read in the reset cycle is ignored.

## Timing
- Write latency: a word written at edge N is counted at edge N; empty falls after edge N.
- Standard mode read latency is 1 cycle. dout updates at the edge where the read is accepted, with mem[raddr]. Otherwise dout holds.
- All flags reflect count after each edge; there are no additional pipeline stages.
- Full throughput is one write and one read per cycle.

## Configuration
- FIFO_FWFT_EN defined (first-word-fall-through):
  - dout is combinationally mem[raddr] and is valid whenever !empty. rd_en acknowledges and pops the head word.
  - dout is don't-care when empty.
  - The reset value of dout is then undefined, but empty = 1.
- FIFO_FWFT_EN not defined: standard registered-read behaviour, as described above.
- All other behaviour is identical in both modes.

## Structure
- Shared package fifo_pkg holds the width helper for count/threshold width (ADDR_WIDTH+1) and the common pointer type conventions used by the team's FIFOs.
- Sub-module fifo_mem is a simple dual-port RAM (one write port, one read port, DATA_WIDTH x DEPTH) with a registered or combinational read selected by the top-level mode.
- Pointer/count logic, flag logic and error flags stay in the top level.

## Test plan
- Reset, then write 16 words 0x00..0x0F (DEPTH=16, af_thresh=14) -> count=16, full=1; almost_full rises at count=14. Reading all 16 returns 0x00..0x0F in order, and empty=1 afterwards.
- Full FIFO, then wr_en with din=0xAA -> write rejected, overflow=1, count stays 16. Later pulse clr_err -> overflow=0.
- Empty FIFO, then rd_en -> underflow=1, dout unchanged, count=0. Same cycle as clr_err -> underflow stays 1.
- Full FIFO with wr_en and rd_en together -> count 15, oldest word read, overflow=1. Empty FIFO with both -> count 1, underflow=1.
- Sustained simultaneous read and write for 40 cycles at count=8 -> count constant at 8, data order preserved across pointer wrap.
- Change ae_thresh from 2 to 10 at count=5 -> almost_empty goes 0 -> 1 in the same cycle. Assert rst mid-stream -> count=0, dout=0, empty=1 next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the team's FIFOs: count/threshold width helper and
// the accepted-operation type used by the pointer logic.
package fifo_pkg;

  // Count and threshold width: one extra bit so occupancy can reach DEPTH.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Accepted operations for the current cycle (after full/empty gating).
  typedef struct packed {
    logic wr;
    logic rd;
  } fifo_op_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM, DATA_WIDTH x 2**ADDR_WIDTH.
// FIFO_FWFT_EN defined   : combinational read (first-word-fall-through).
// FIFO_FWFT_EN undefined : registered read, rdata cleared by rst, holds otherwise.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port; storage is never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible as soon as it is stored; re/rst only matter upstream.
  logic unused_ctl;
  assign unused_ctl = re ^ rst;
  assign rdata = mem[raddr];
`else
  // Registered read: update only on an accepted read, else hold.
  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/fifo_prog_flags.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count and sticky overflow/underflow flags.
// Read mode follows FIFO_FWFT_EN (see fifo_mem).
module fifo_prog_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int            CW      = cnt_width(ADDR_WIDTH);
  localparam int            DEPTH   = 2**ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] wptr, rptr, cnt;
  fifo_op_t      acc;

  // Flags straight from the count register; thresholds act immediately.
  // af_thresh==0 and ae_thresh>=DEPTH fall out of the compares naturally.
  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= af_thresh);
  assign almost_empty = (cnt <= ae_thresh);
  assign count        = cnt;

  // Accept only what the pre-edge full/empty state allows.
  always_comb begin
    acc.wr = wr_en && !full;
    acc.rd = rd_en && !empty;
  end

  // Pointers and occupancy; pointers wrap modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (acc.wr) wptr <= wptr + ONE;
      if (acc.rd) rptr <= rptr + ONE;
      case ({acc.wr, acc.rd})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

  // Operations in the reset cycle must not touch storage or dout.
  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (acc.wr && rst),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (din),
    .re    (acc.rd && rst),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (dout)
  );

endmodule

// File: tb/tb_fifo_prog_flags.sv
// Self-checking bench for fifo_prog_flags (DEPTH=16). Reference model is a
// queue plus sticky flags; every output is compared after each clock edge.
module tb_fifo_prog_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] af_thresh = 5'd14, ae_thresh = 5'd2;
  logic [4:0] count;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [7:0] q[$];
  logic       m_ovf = 1'b0, m_unf = 1'b0;
  logic [7:0] m_dout = '0;

  fifo_prog_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == 16));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= int'(af_thresh)));
    chk("almost_empty", 32'(almost_empty), 32'(n <= int'(ae_thresh)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_FWFT_EN
    if (n > 0) chk("dout_head", 32'(dout), 32'(q[0]));
`else
    chk("dout", 32'(dout), 32'(m_dout));
`endif
  endtask

  // One clock: drive inputs, advance the model on pre-edge state, compare.
  task automatic step(input logic r, input logic we, input logic [7:0] d,
                      input logic re, input logic ce);
    bit was_full, was_empty;
    rst = r; wr_en = we; din = d; rd_en = re; clr_err = ce;
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    end else begin
      was_full  = (q.size() == 16);
      was_empty = (q.size() == 0);
      if (re && !was_empty) m_dout = q.pop_front();
      if (we && !was_full) q.push_back(d);
      if (we && was_full) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
      if (re && was_empty) m_unf = 1'b1; else if (ce) m_unf = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    // reset, with af_thresh=0 forcing almost_full
    af_thresh = 5'd0;
    step(0, 1, 8'h55, 1, 0);
    step(0, 0, 8'h00, 0, 0);
    af_thresh = 5'd14;
    #1;
    chk("reset_af14", 32'(almost_full), 32'd0);

    // fill 0x00..0x0F, almost_full rises at 14
    for (int i = 0; i < 16; i++) step(1, 1, 8'(i), 0, 0);
    // write while full -> overflow, then clear
    step(1, 1, 8'hAA, 0, 0);
    step(1, 0, 8'h00, 0, 1);
    // drain in order
    for (int i = 0; i < 16; i++) step(1, 0, 8'h00, 1, 0);
    // read while empty -> underflow; clear in same cycle as another underflow
    step(1, 0, 8'h00, 1, 0);
    step(1, 0, 8'h00, 1, 1);
    step(1, 0, 8'h00, 0, 1);

    // full with read+write: read wins, overflow set
    for (int i = 0; i < 16; i++) step(1, 1, 8'(8'h30 + i), 0, 0);
    step(1, 1, 8'hBB, 1, 0);
    while (q.size() > 0) step(1, 0, 8'h00, 1, 0);
    // empty with read+write: write wins, underflow set
    step(1, 1, 8'hCC, 1, 0);
    step(1, 0, 8'h00, 0, 1);

    // sustained read+write at count 8 across pointer wrap
    while (q.size() < 8) step(1, 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 8'($urandom), 1, 0);

    // ae_thresh change takes effect without a clock
    while (q.size() > 5) step(1, 0, 8'h00, 1, 0);
    ae_thresh = 5'd2;
    #1;
    chk("ae_thr2", 32'(almost_empty), 32'd0);
    ae_thresh = 5'd10;
    #1;
    chk("ae_thr10", 32'(almost_empty), 32'd1);

    // randomized traffic with varying bias and thresholds
    for (int i = 0; i < 400; i++) begin
      int p;
      if (i % 50 == 0) begin
        af_thresh = 5'($urandom_range(0, 20));
        ae_thresh = 5'($urandom_range(0, 20));
      end
      p = ((i / 100) % 2 == 0) ? 75 : 25;
      step(1, ($urandom % 100) < p, 8'($urandom), ($urandom % 100) < (100 - p),
           ($urandom % 16) == 0);
    end

    // mid-stream reset discards contents
    while (q.size() < 6) step(1, 1, 8'($urandom), 0, 0);
    step(0, 1, 8'h77, 1, 0);
    chk("rst_count", 32'(count), 32'd0);
`ifndef FIFO_FWFT_EN
    chk("rst_dout", 32'(dout), 32'd0);
`endif
    step(1, 0, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
